// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the extended sysid block.
// Single-cycle read/write strobes, no waitrequest, registered readdatavalid.
interface nios_system_sysid_ext_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/nios_system_sysid_ext.sv
// System-identification slave: build ID, timestamp, version, uptime counter with
// atomic LO/HI snapshot, scratch and control registers. One-cycle read latency.
module nios_system_sysid_ext #(
    parameter logic [31:0] ID            = 32'd1449376543,
    parameter logic [31:0] TIMESTAMP     = 32'd0,
    parameter logic [31:0] VERSION       = 32'h0002_0000,
    parameter int          UPTIME_W      = 64,
    parameter logic [31:0] SCRATCH_RESET = 32'd0
) (
    input logic                     clock,
    input logic                     reset,
    nios_system_sysid_ext_if.slave  bus
);
    // UPTIME_W must lie in 33..64 so the high word is non-empty and fits 32 bits.
    localparam int HI_W = UPTIME_W - 32;

    typedef enum logic [2:0] {
        ADDR_ID        = 3'd0,
        ADDR_TIMESTAMP = 3'd1,
        ADDR_UPTIME_LO = 3'd2,
        ADDR_UPTIME_HI = 3'd3,
        ADDR_SCRATCH   = 3'd4,
        ADDR_CTRL      = 3'd5,
        ADDR_VERSION   = 3'd6,
        ADDR_RESERVED  = 3'd7
    } reg_addr_e;

    logic [UPTIME_W-1:0] cnt;
    logic [31:0]         shadow;
    logic [31:0]         scratch;
    logic                freeze;

    logic [31:0] cnt_hi_ext;
    logic [31:0] rd_mux;
    logic        wr_ctrl;
    logic        wr_scratch;
    logic        clear;
    logic        rd_lo;

    always_comb begin
        cnt_hi_ext             = '0;
        cnt_hi_ext[HI_W-1:0]   = cnt[UPTIME_W-1:32];
        wr_ctrl                = bus.write && (bus.address == ADDR_CTRL);
        wr_scratch             = bus.write && (bus.address == ADDR_SCRATCH);
        clear                  = wr_ctrl && bus.writedata[1];
        rd_lo                  = bus.read && (bus.address == ADDR_UPTIME_LO);
    end

    // Read mux sees the registers before this edge's write, so a same-cycle
    // read/write returns the old contents.
    always_comb begin
        rd_mux = '0;
        unique case (reg_addr_e'(bus.address))
            ADDR_ID:        rd_mux = ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_UPTIME_LO: rd_mux = cnt[31:0];
            ADDR_UPTIME_HI: rd_mux = shadow;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_CTRL:      rd_mux = {31'd0, freeze};
            ADDR_VERSION:   rd_mux = VERSION;
            ADDR_RESERVED:  rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the snapshot relies on this.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= cnt + UPTIME_W'(1);
        end
    end

    // Shadow latches the high bits of the same value returned by a LO read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (rd_lo) begin
            shadow <= cnt_hi_ext;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= SCRATCH_RESET;
            freeze  <= 1'b0;
        end else begin
            if (wr_scratch) scratch <= bus.writedata;
            if (wr_ctrl)    freeze  <= bus.writedata[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) bus.readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Directed bench for nios_system_sysid_ext: reads are queued with their expected
// data and checked by a monitor when readdatavalid appears.
module tb_nios_system_sysid_ext;
    localparam logic [31:0] P_ID      = 32'd1449376543;
    localparam logic [31:0] P_TS      = 32'h6543_2100;
    localparam logic [31:0] P_VER     = 32'h0002_0000;
    localparam logic [31:0] P_SCR_RST = 32'hA5A5_0F0F;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          care;
    } sb_entry_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    sb_entry_t sb[$];

    nios_system_sysid_ext_if bus ();
    nios_system_sysid_ext_if bus40 ();

    nios_system_sysid_ext #(
        .ID(P_ID), .TIMESTAMP(P_TS), .VERSION(P_VER),
        .UPTIME_W(64), .SCRATCH_RESET(P_SCR_RST)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    nios_system_sysid_ext #(
        .UPTIME_W(40)
    ) u40 (
        .clock(clock), .reset(reset), .bus(bus40)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every readdatavalid must match the oldest outstanding read.
    always @(posedge clock) begin
        #1;
        if (bus.readdatavalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                if (e.care) check(e.tag, bus.readdata, e.exp);
            end
        end
    end

    // Each bus task starts and ends at a falling edge and consumes one cycle.
    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag,
                      input bit care = 1'b1);
        sb_entry_t e;
        e.tag = tag; e.exp = exp; e.care = care;
        sb.push_back(e);
        bus.address = addr; bus.read = 1'b1; bus.write = 1'b0;
        @(negedge clock);
        bus.read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus.address = addr; bus.writedata = data; bus.write = 1'b1; bus.read = 1'b0;
        @(negedge clock);
        bus.write = 1'b0;
    endtask

    task automatic rw(input logic [2:0] addr, input logic [31:0] data,
                      input logic [31:0] exp, input string tag);
        sb_entry_t e;
        e.tag = tag; e.exp = exp; e.care = 1'b1;
        sb.push_back(e);
        bus.address = addr; bus.writedata = data; bus.write = 1'b1; bus.read = 1'b1;
        @(negedge clock);
        bus.write = 1'b0; bus.read = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.read = 1'b0; bus.write = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic rd40(input logic [2:0] addr, output logic [31:0] data, output logic v);
        bus40.address = addr; bus40.read = 1'b1;
        @(negedge clock);
        bus40.read = 1'b0;
        v    = bus40.readdatavalid;
        data = bus40.readdata;
    endtask

    initial begin
        logic [31:0] lo40;
        logic [31:0] hi40;
        logic        v40;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        bus40.address = '0; bus40.read = 1'b0; bus40.write = 1'b0; bus40.writedata = '0;
        repeat (3) @(negedge clock);
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_valid", 32'(bus.readdatavalid), 32'd0);
        reset = 1'b0;
        idle(1);

        // Identification words, back-to-back.
        rd(3'd0, P_ID,  "rd_id");
        rd(3'd1, P_TS,  "rd_timestamp");
        rd(3'd6, P_VER, "rd_version");
        rd(3'd7, 32'd0, "rd_reserved");
        rd(3'd3, 32'd0, "rd_hi_after_reset");
        rd(3'd0, P_ID,  "rd_id_again");
        idle(2);
        check("hold_readdata", bus.readdata, P_ID);
        check("hold_valid_low", 32'(bus.readdatavalid), 32'd0);

        // Scratch and ignored writes.
        wr(3'd4, 32'hDEAD_BEEF);
        rd(3'd4, 32'hDEAD_BEEF, "scratch_wr");
        rw(3'd4, 32'h1234_5678, 32'hDEAD_BEEF, "scratch_rw_old");
        rd(3'd4, 32'h1234_5678, "scratch_rw_new");
        wr(3'd7, 32'hFFFF_FFFF);
        wr(3'd0, 32'h0000_0000);
        rd(3'd7, 32'd0, "reserved_wr_ignored");
        rd(3'd0, P_ID,  "id_wr_ignored");

        // Freeze + clear, then clear alone.
        wr(3'd5, 32'd3);
        rd(3'd2, 32'd0, "freeze_lo_a");
        idle(10);
        rd(3'd2, 32'd0, "freeze_lo_b");
        rd(3'd5, 32'd1, "ctrl_freeze_rb");
        wr(3'd5, 32'd2);
        idle(4);
        rd(3'd2, 32'd4, "clear_count");
        rd(3'd5, 32'd0, "ctrl_cleared_rb");

        // Atomic snapshot across a 32-bit carry.
        force dut.cnt = 64'h0000_0000_FFFF_FFFE;
        rd(3'd2, 32'hFFFF_FFFE, "carry_lo");
        release dut.cnt;
        idle(5);
        rd(3'd3, 32'd0, "carry_hi_snapshot");
        rd(3'd2, 32'd0, "carry_lo_live", 1'b0);
        rd(3'd3, 32'd1, "carry_hi_live");
        idle(3);
        check("sb_drained_mid", 32'(sb.size()), 32'd0);

        // Reset one cycle after a read: pending and later data must vanish.
        rd(3'd4, 32'h1234_5678, "pre_reset_rd");
        bus.address = 3'd4; bus.read = 1'b1; reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.readdatavalid), 32'd0);
        check("mid_rst_data", bus.readdata, 32'd0);
        @(negedge clock);
        check("in_rst_valid", 32'(bus.readdatavalid), 32'd0);
        reset = 1'b0; bus.read = 1'b0;
        @(negedge clock);
        check("post_rst_valid", 32'(bus.readdatavalid), 32'd0);
        check("post_rst_data", bus.readdata, 32'd0);
        rd(3'd4, P_SCR_RST, "scratch_after_rst");
        rd(3'd3, 32'd0,     "shadow_after_rst");
        rd(3'd5, 32'd0,     "freeze_after_rst");
        idle(2);

        // 40-bit counter wrap.
        force u40.cnt = 40'hFF_FFFF_FFFD;
        @(negedge clock);
        release u40.cnt;
        rd40(3'd2, lo40, v40);
        check("u40_valid", 32'(v40), 32'd1);
        check("u40_lo_near_top", 32'(lo40 >= 32'hFFFF_FFF0), 32'd1);
        rd40(3'd3, hi40, v40);
        check("u40_hi_top", hi40, 32'h0000_00FF);
        repeat (6) @(negedge clock);
        rd40(3'd2, lo40, v40);
        check("u40_lo_wrapped", 32'(lo40 < 32'd16), 32'd1);
        rd40(3'd3, hi40, v40);
        check("u40_hi_wrapped", hi40, 32'd0);

        idle(3);
        check("sb_drained_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
